// File: rtl/image_in_wr_arbiter.sv
// Round-robin scheduler draining CH_NUM image input FIFOs into one DDR write-burst port.
// Define IMG_ARB_PINGPONG_EN for per-channel ping-pong frame buffers and the buf_sel port.
module image_in_wr_arbiter #(
   parameter int CH_NUM       = 4,
   parameter int DATA_W       = 256,
   parameter int LEVEL_W      = 11,
   parameter int ADDR_W       = 28,
   parameter int BURST_LEN    = 16,
   parameter int FRAME_WORDS  = 129600,
   parameter int CH_STRIDE    = 'h400000
`ifdef IMG_ARB_PINGPONG_EN
   , parameter int FRAME_STRIDE = 'h200000
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CH_NUM-1:0]         ch_enable,
   input  logic [CH_NUM-1:0]         frame_start,
   input  logic [CH_NUM*LEVEL_W-1:0] fifo_rd_water_level,
   input  logic [CH_NUM-1:0]         fifo_rd_empty,
   input  logic [CH_NUM*DATA_W-1:0]  fifo_rd_data,
   output logic [CH_NUM-1:0]         fifo_rd_en,
   output logic                      wr_req,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [7:0]                wr_len,
   input  logic                      wr_ack,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      wr_data_valid,
   output logic                      wr_data_last,
   input  logic                      wr_data_ready,
   output logic [CH_NUM-1:0]         frame_done,
`ifdef IMG_ARB_PINGPONG_EN
   output logic [CH_NUM-1:0]         buf_sel,
`endif
   output logic                      busy
);
   localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
   state_t state, state_next;

   logic [GW-1:0]     grant, last_grant, pick;
   logic              found;
   logic [CH_NUM-1:0] eligible, grant_onehot, pending;
   logic [ADDR_W-1:0] offset [CH_NUM];
   logic [ADDR_W-1:0] base_addr;
   logic [CW-1:0]     issued, beat_cnt;
   logic              inflight, push, pop, last_beat, wrap, restart;
   logic [DATA_W-1:0] skid_mem [2];
   logic              skid_rd_ptr, skid_wr_ptr;
   logic [1:0]        skid_cnt;
`ifdef IMG_ARB_PINGPONG_EN
   logic [CH_NUM-1:0] buf_cur;
   assign buf_sel = ~buf_cur;
`endif

   always_comb begin
      eligible = '0;
      for (int c = 0; c < CH_NUM; c++)
         eligible[c] = ch_enable[c] &&
            (32'(fifo_rd_water_level[c*LEVEL_W +: LEVEL_W]) >= 32'(BURST_LEN));
   end

   // Search starts one past the previous winner so every channel gets its turn.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 1; i <= CH_NUM; i++) begin
         if (!found && eligible[(int'(last_grant) + i) % CH_NUM]) begin
            found = 1'b1;
            pick  = GW'((int'(last_grant) + i) % CH_NUM);
         end
      end
   end

   always_comb begin
      grant_onehot = CH_NUM'(1) << grant;
      wrap         = (offset[grant] + ADDR_W'(BURST_LEN)) >= ADDR_W'(FRAME_WORDS);
      restart      = pending[grant] | frame_start[grant];
      last_beat    = beat_cnt == CW'(BURST_LEN - 1);
      push         = inflight;
      base_addr    = ADDR_W'(grant) * ADDR_W'(CH_STRIDE) + offset[grant];
`ifdef IMG_ARB_PINGPONG_EN
      if (buf_cur[grant])
         base_addr = base_addr + ADDR_W'(FRAME_STRIDE);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = REQ;
         REQ:     if (wr_ack) state_next = DATA;
         DATA:    if (pop && last_beat) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reads are throttled so skid contents plus the read in flight never exceed two beats.
   always_comb begin
      wr_req        = state == REQ;
      wr_addr       = wr_req ? base_addr : '0;
      wr_len        = wr_req ? 8'(BURST_LEN - 1) : '0;
      busy          = state != IDLE;
      fifo_rd_en    = '0;
      if (state == DATA && issued < CW'(BURST_LEN) && !fifo_rd_empty[grant] &&
          (skid_cnt + {1'b0, inflight}) < 2'd2)
         fifo_rd_en = grant_onehot;
      wr_data_valid = skid_cnt != 2'd0;
      wr_data       = wr_data_valid ? skid_mem[skid_rd_ptr] : '0;
      wr_data_last  = wr_data_valid && last_beat;
      pop           = wr_data_valid && wr_data_ready;
      frame_done    = (state == DONE && wrap) ? grant_onehot : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= '0;
         last_grant  <= GW'(CH_NUM - 1);
         issued      <= '0;
         beat_cnt    <= '0;
         inflight    <= 1'b0;
         skid_cnt    <= '0;
         skid_rd_ptr <= 1'b0;
         skid_wr_ptr <= 1'b0;
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
      end else begin
         inflight <= |fifo_rd_en;
         if (state == IDLE && found) grant <= pick;
         if (state == DONE) last_grant <= grant;
         if (state == REQ) begin
            issued   <= '0;
            beat_cnt <= '0;
         end else begin
            if (|fifo_rd_en) issued <= issued + 1'b1;
            if (pop) beat_cnt <= beat_cnt + 1'b1;
         end
         if (push) begin
            skid_mem[skid_wr_ptr] <= fifo_rd_data[grant*DATA_W +: DATA_W];
            skid_wr_ptr           <= ~skid_wr_ptr;
         end
         if (pop) skid_rd_ptr <= ~skid_rd_ptr;
         skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // A restart on the channel being served is deferred so its burst address stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         for (int c = 0; c < CH_NUM; c++) offset[c] <= '0;
`ifdef IMG_ARB_PINGPONG_EN
         buf_cur <= '0;
`endif
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (state == DONE && GW'(c) == grant) begin
               pending[c] <= 1'b0;
               if (wrap || restart) offset[c] <= '0;
               else                 offset[c] <= offset[c] + ADDR_W'(BURST_LEN);
`ifdef IMG_ARB_PINGPONG_EN
               if (wrap) buf_cur[c] <= ~buf_cur[c];
`endif
            end else if (frame_start[c]) begin
               if (busy && GW'(c) == grant) pending[c] <= 1'b1;
               else                         offset[c]  <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_image_in_wr_arbiter.sv
// Directed testbench for image_in_wr_arbiter with a behavioural FIFO per channel.
// Word k read from channel c carries {c[7:0], k[23:0]} so beat order is checkable.
`timescale 1ns/1ps
module tb_image_in_wr_arbiter;
   localparam int CH_NUM      = 4;
   localparam int DATA_W      = 32;
   localparam int LEVEL_W     = 11;
   localparam int ADDR_W      = 28;
   localparam int BURST_LEN   = 16;
   localparam int FRAME_WORDS = 64;
   localparam int CH_STRIDE   = 'h1000;
`ifdef IMG_ARB_PINGPONG_EN
   localparam logic [27:0] WRAP_ADDR = 28'h1000 + 28'h200000;
`else
   localparam logic [27:0] WRAP_ADDR = 28'h1000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [CH_NUM-1:0]         ch_enable = '1;
   logic [CH_NUM-1:0]         frame_start = '0;
   logic [CH_NUM*LEVEL_W-1:0] fifo_rd_water_level;
   logic [CH_NUM-1:0]         fifo_rd_empty;
   logic [CH_NUM*DATA_W-1:0]  fifo_rd_data;
   logic [CH_NUM-1:0]         fifo_rd_en;
   logic                      wr_req;
   logic [ADDR_W-1:0]         wr_addr;
   logic [7:0]                wr_len;
   logic                      wr_ack = 1'b1;
   logic [DATA_W-1:0]         wr_data;
   logic                      wr_data_valid, wr_data_last, wr_data_ready;
   logic [CH_NUM-1:0]         frame_done;
   logic                      busy;
`ifdef IMG_ARB_PINGPONG_EN
   logic [CH_NUM-1:0]         buf_sel;
`endif

   int checks = 0;
   int failures = 0;
   int fill [CH_NUM] = '{0, 0, 0, 0};
   int reads [CH_NUM];
   logic [DATA_W-1:0] rd_data_q [CH_NUM];
   logic ready_base = 1'b1;
   logic ready_toggle_en = 1'b0;
   logic toggle_bit = 1'b0;

   int n_cmd = 0, n_beat = 0, n_last = 0;
   logic [27:0] cmd_addr [$];
   logic [7:0]  cmd_len [$];
   logic [31:0] beat_data [$];
   logic        beat_last [$];
   int viol_empty = 0, viol_onehot = 0;
   int mon_reads = 0, mon_beats = 0, max_occ = 0;
   int fd_cnt [CH_NUM] = '{0, 0, 0, 0};
   int fd_at [CH_NUM] = '{0, 0, 0, 0};

   image_in_wr_arbiter #(
      .CH_NUM(CH_NUM), .DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .ADDR_W(ADDR_W),
      .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .CH_STRIDE(CH_STRIDE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_enable(ch_enable), .frame_start(frame_start),
      .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack), .wr_data(wr_data),
      .wr_data_valid(wr_data_valid), .wr_data_last(wr_data_last),
      .wr_data_ready(wr_data_ready), .frame_done(frame_done),
`ifdef IMG_ARB_PINGPONG_EN
      .buf_sel(buf_sel),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) toggle_bit <= ~toggle_bit;
   assign wr_data_ready = ready_toggle_en ? toggle_bit : ready_base;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH_NUM; c++) begin
            reads[c]     <= 0;
            rd_data_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH_NUM; c++)
            if (fifo_rd_en[c]) begin
               rd_data_q[c] <= {8'(c), 24'(reads[c])};
               reads[c]     <= reads[c] + 1;
            end
      end
   end

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         fifo_rd_water_level[c*LEVEL_W +: LEVEL_W] = LEVEL_W'(fill[c] - reads[c]);
         fifo_rd_empty[c] = (fill[c] - reads[c]) <= 0;
         fifo_rd_data[c*DATA_W +: DATA_W] = rd_data_q[c];
      end
   end

   // Passive observer sampling mid-cycle; tests read its logs by index.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_reads = 0;
         mon_beats = 0;
         max_occ   = 0;
      end else begin
         if (wr_req && wr_ack) begin
            cmd_addr.push_back(wr_addr);
            cmd_len.push_back(wr_len);
            n_cmd++;
         end
         if (wr_data_valid && wr_data_ready) begin
            beat_data.push_back(wr_data);
            beat_last.push_back(wr_data_last);
            n_beat++;
            mon_beats++;
            if (wr_data_last) n_last++;
         end
         if ($countones(fifo_rd_en) > 1) viol_onehot++;
         for (int c = 0; c < CH_NUM; c++) begin
            if (fifo_rd_en[c]) begin
               mon_reads++;
               if (fill[c] - reads[c] <= 0) viol_empty++;
            end
            if (frame_done[c]) begin
               fd_cnt[c]++;
               fd_at[c] = n_last;
            end
         end
         if (mon_reads - mon_beats > max_occ) max_occ = mon_reads - mon_beats;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      ch_enable = '1;
      frame_start = '0;
      wr_ack = 1'b1;
      ready_base = 1'b1;
      ready_toggle_en = 1'b0;
      for (int c = 0; c < CH_NUM; c++) fill[c] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_bursts(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (n_last >= target && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rd(input int ch, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fifo_rd_en[ch]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fill[0] = 20;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wr_req, busy, wr_data_valid, wr_data_last} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000", {wr_req, busy, wr_data_valid, wr_data_last});
      end
      checks++;
      if (fifo_rd_en !== 4'b0 || frame_done !== 4'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobes: got rd_en=%b frame_done=%b expected 0", fifo_rd_en, frame_done);
      end
      checks++;
      if (wr_addr !== 28'h0 || wr_len !== 8'h0 || wr_data !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_buses: got addr=%h len=%h data=%h expected 0", wr_addr, wr_len, wr_data);
      end
      do_reset();
   endtask

   task automatic test_single_burst();
      int s_cmd, s_beat, errs;
      bit ok, seen;
      do_reset();
      wr_ack = 1'b0;
      s_cmd = n_cmd;
      s_beat = n_beat;
      fill[0] = 20;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = wr_req;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL single_req: got no wr_req expected wr_req within 20 cycles");
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_req !== 1'b1 || wr_addr !== 28'h0 || wr_len !== 8'd15 || fifo_rd_en !== 4'b0) begin
         failures++;
         $display("[TB] FAIL single_hold: got req=%b addr=%h len=%0d rd_en=%b expected 1 0 15 0",
                  wr_req, wr_addr, wr_len, fifo_rd_en);
      end
      @(posedge clk);
      #1 wr_ack = 1'b1;
      wait_bursts(n_last + 1, ok);
      checks++;
      if (!ok || n_cmd - s_cmd != 1 || reads[0] != 16 || n_beat - s_beat != 16) begin
         failures++;
         $display("[TB] FAIL single_counts: got done=%0d cmds=%0d reads=%0d beats=%0d expected 1 1 16 16",
                  ok, n_cmd - s_cmd, reads[0], n_beat - s_beat);
      end
      checks++;
      if (n_cmd - s_cmd < 1 || cmd_addr[s_cmd] !== 28'h0 || cmd_len[s_cmd] !== 8'd15) begin
         failures++;
         $display("[TB] FAIL single_cmd: got cmds=%0d expected addr 0000000 len 15", n_cmd - s_cmd);
      end
      errs = 16;
      if (n_beat - s_beat >= 16) begin
         errs = 0;
         for (int k = 0; k < 16; k++)
            if (beat_data[s_beat+k] !== {8'd0, 24'(k)} || beat_last[s_beat+k] !== (k == 15)) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("[TB] FAIL single_beats: got %0d bad beats expected 0", errs);
      end
      checks++;
      if (viol_empty != 0 || viol_onehot != 0) begin
         failures++;
         $display("[TB] FAIL rd_en_rules: got empty_reads=%0d multi_hot=%0d expected 0 0", viol_empty, viol_onehot);
      end
   endtask

   task automatic test_round_robin();
      logic [27:0] exp_addr [5] = '{28'h0000, 28'h1000, 28'h2000, 28'h3000, 28'h0010};
      int s_cmd, s_beat, errs;
      bit ok;
      do_reset();
      s_cmd = n_cmd;
      s_beat = n_beat;
      fill[0] = 32; fill[1] = 16; fill[2] = 16; fill[3] = 16;
      wait_bursts(n_last + 5, ok);
      checks++;
      if (!ok || n_cmd - s_cmd != 5) begin
         failures++;
         $display("[TB] FAIL rr_count: got done=%0d cmds=%0d expected 1 5", ok, n_cmd - s_cmd);
      end
      for (int i = 0; i < 5; i++) begin
         if (n_cmd - s_cmd > i) begin
            checks++;
            if (cmd_addr[s_cmd+i] !== exp_addr[i]) begin
               failures++;
               $display("[TB] FAIL rr_addr%0d: got %h expected %h", i, cmd_addr[s_cmd+i], exp_addr[i]);
            end
         end
      end
      errs = 16;
      if (n_beat - s_beat >= 80) begin
         errs = 0;
         for (int k = 0; k < 16; k++)
            if (beat_data[s_beat+64+k] !== {8'd0, 24'(16 + k)}) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("[TB] FAIL rr_ch0_second_data: got %0d bad beats expected 0", errs);
      end
   endtask

   task automatic test_ready_toggle();
      int s_cmd, s_beat, errs;
      bit ok;
      do_reset();
      ready_toggle_en = 1'b1;
      s_cmd = n_cmd;
      s_beat = n_beat;
      fill[2] = 16;
      wait_bursts(n_last + 1, ok);
      ready_toggle_en = 1'b0;
      checks++;
      if (!ok || n_beat - s_beat != 16 || reads[2] != 16 || n_cmd - s_cmd != 1) begin
         failures++;
         $display("[TB] FAIL toggle_counts: got done=%0d beats=%0d reads=%0d cmds=%0d expected 1 16 16 1",
                  ok, n_beat - s_beat, reads[2], n_cmd - s_cmd);
      end
      errs = 16;
      if (n_beat - s_beat >= 16) begin
         errs = 0;
         for (int k = 0; k < 16; k++)
            if (beat_data[s_beat+k] !== {8'd2, 24'(k)} || beat_last[s_beat+k] !== (k == 15)) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("[TB] FAIL toggle_order: got %0d bad beats expected 0", errs);
      end
      checks++;
      if (max_occ > 2) begin
         failures++;
         $display("[TB] FAIL toggle_buffered: got %0d expected at most 2", max_occ);
      end
      checks++;
      if (n_cmd - s_cmd < 1 || cmd_addr[s_cmd] !== 28'h2000) begin
         failures++;
         $display("[TB] FAIL toggle_addr: got cmds=%0d expected addr 2000", n_cmd - s_cmd);
      end
   endtask

   task automatic test_frame_wrap();
      logic [27:0] exp_addr [5] = '{28'h1000, 28'h1010, 28'h1020, 28'h1030, WRAP_ADDR};
      int s_cmd, s_last, s_fd1, s_fd_other;
      bit ok;
      do_reset();
      s_cmd = n_cmd;
      s_last = n_last;
      s_fd1 = fd_cnt[1];
      s_fd_other = fd_cnt[0] + fd_cnt[2] + fd_cnt[3];
      fill[1] = 80;
      wait_bursts(n_last + 5, ok);
      checks++;
      if (!ok || n_cmd - s_cmd != 5) begin
         failures++;
         $display("[TB] FAIL wrap_count: got done=%0d cmds=%0d expected 1 5", ok, n_cmd - s_cmd);
      end
      for (int i = 0; i < 5; i++) begin
         if (n_cmd - s_cmd > i) begin
            checks++;
            if (cmd_addr[s_cmd+i] !== exp_addr[i]) begin
               failures++;
               $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, cmd_addr[s_cmd+i], exp_addr[i]);
            end
         end
      end
      checks++;
      if (fd_cnt[1] - s_fd1 != 1 || fd_at[1] - s_last != 4) begin
         failures++;
         $display("[TB] FAIL wrap_frame_done: got pulses=%0d at_burst=%0d expected 1 4",
                  fd_cnt[1] - s_fd1, fd_at[1] - s_last);
      end
      checks++;
      if (fd_cnt[0] + fd_cnt[2] + fd_cnt[3] != s_fd_other) begin
         failures++;
         $display("[TB] FAIL wrap_other_done: got %0d expected %0d", fd_cnt[0] + fd_cnt[2] + fd_cnt[3], s_fd_other);
      end
   endtask

   task automatic test_frame_start();
      logic [27:0] exp_addr [6] = '{28'h1000, 28'h2000, 28'h2010, 28'h2020, 28'h1000, 28'h2000};
      int s_cmd, s_fd;
      bit ok, ok2, ok3, ok4;
      do_reset();
      s_cmd = n_cmd;
      s_fd = fd_cnt[1] + fd_cnt[2];
      fill[1] = 16;
      fill[2] = 32;
      wait_bursts(n_last + 3, ok);
      fill[2] = 48;
      wait_rd(2, ok2);
      frame_start = 4'b0110;
      @(posedge clk);
      #1 frame_start = 4'b0000;
      wait_bursts(n_last + 1, ok3);
      fill[1] = 32;
      fill[2] = 64;
      wait_bursts(n_last + 2, ok4);
      checks++;
      if (!(ok && ok2 && ok3 && ok4) || n_cmd - s_cmd != 6) begin
         failures++;
         $display("[TB] FAIL fstart_count: got done=%0d%0d%0d%0d cmds=%0d expected 1111 6",
                  ok, ok2, ok3, ok4, n_cmd - s_cmd);
      end
      for (int i = 0; i < 6; i++) begin
         if (n_cmd - s_cmd > i) begin
            checks++;
            if (cmd_addr[s_cmd+i] !== exp_addr[i]) begin
               failures++;
               $display("[TB] FAIL fstart_addr%0d: got %h expected %h", i, cmd_addr[s_cmd+i], exp_addr[i]);
            end
         end
      end
      checks++;
      if (fd_cnt[1] + fd_cnt[2] != s_fd) begin
         failures++;
         $display("[TB] FAIL fstart_no_done: got %0d pulses expected 0", fd_cnt[1] + fd_cnt[2] - s_fd);
      end
   endtask

   task automatic test_enable_drop();
      int s_cmd, s_beat;
      bit ok, ok2;
      do_reset();
      s_cmd = n_cmd;
      s_beat = n_beat;
      fill[0] = 32;
      wait_rd(0, ok);
      ch_enable[0] = 1'b0;
      wait_bursts(n_last + 1, ok2);
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (!(ok && ok2) || n_cmd - s_cmd != 1 || n_beat - s_beat != 16 || reads[0] != 16 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL enable_drop: got done=%0d%0d cmds=%0d beats=%0d reads=%0d busy=%b expected 11 1 16 16 0",
                  ok, ok2, n_cmd - s_cmd, n_beat - s_beat, reads[0], busy);
      end
      ch_enable = '1;
   endtask

   task automatic test_reset_mid_burst();
      int s_cmd;
      bit ok, ok2, ok3;
      do_reset();
      fill[0] = 16;
      wait_bursts(n_last + 1, ok);
      fill[0] = 32;
      wait_rd(0, ok2);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      for (int c = 0; c < CH_NUM; c++) fill[c] = 0;
      #1;
      checks++;
      if ({wr_req, busy, wr_data_valid, wr_data_last} !== 4'b0 || fifo_rd_en !== 4'b0 || wr_addr !== 28'h0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: got ctrl=%b rd_en=%b addr=%h expected 0",
                  {wr_req, busy, wr_data_valid, wr_data_last}, fifo_rd_en, wr_addr);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      s_cmd = n_cmd;
      fill[0] = 16;
      fill[1] = 16;
      wait_bursts(n_last + 2, ok3);
      checks++;
      if (!(ok && ok2 && ok3) || n_cmd - s_cmd != 2) begin
         failures++;
         $display("[TB] FAIL midreset_count: got done=%0d%0d%0d cmds=%0d expected 111 2", ok, ok2, ok3, n_cmd - s_cmd);
      end
      checks++;
      if (n_cmd - s_cmd < 2 || cmd_addr[s_cmd] !== 28'h0000 || cmd_addr[s_cmd+1] !== 28'h1000) begin
         failures++;
         $display("[TB] FAIL midreset_regrant: got cmds=%0d expected addrs 0000 then 1000", n_cmd - s_cmd);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_ready_toggle();
      test_frame_wrap();
      test_frame_start();
      test_enable_drop();
      test_reset_mid_burst();
      checks++;
      if (viol_empty != 0 || viol_onehot != 0) begin
         failures++;
         $display("[TB] FAIL rd_en_rules_final: got empty_reads=%0d multi_hot=%0d expected 0 0", viol_empty, viol_onehot);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
